issue_mem_streamer: RTL and testbench
=====================================

// Module: issue_mem_streamer
// PURPOSE
//  Read-side engine for the 60K x 18 issue memory (1-cycle registered read, no read enable).
//  Accepts {base, len} commands and walks len consecutive words through one memory read port.
//  Returns them as a valid/ready stream with a last flag.
//  Absorbs the memory's fixed read latency with a credit-checked FIFO, so downstream stalls never drop data.
// PARAMETERS
//  ADDR_W      16     memory address width
//  DATA_W      18     memory word width
//  MEM_WORDS   61440  memory depth; addresses wrap modulo this value
//  FIFO_DEPTH  4      output buffer entries (>=3 required for 1 word/cycle)
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst_n      in   1       asynchronous active-low reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       command accepted when cmd_valid && cmd_ready
//  cmd_base   in   ADDR_W  first word address
//  cmd_len    in   16      word count; 0 = no-op
//  mem_addr   out  ADDR_W  read address to memory port (registered)
//  mem_re     out  1       read issued this cycle (tracking/power; memory may ignore it)
//  mem_data   in   DATA_W  memory read data, valid one cycle after issue
//  out_valid  out  1       stream word available
//  out_ready  in   1       downstream accepts word
//  out_data   out  DATA_W  stream word
//  out_last   out  1       final word of current command
//  busy       out  1       high from cmd accept until done
//  done       out  1       one-cycle pulse at command completion
//  err        out  1       one-cycle pulse with done when cmd_base >= MEM_WORDS
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; cmd_ready=1; all other outputs 0; FIFO and counters cleared.
//  - Asserting rst_n=0 mid-command aborts it. No done is produced.
//  FSM IDLE/ISSUE/DRAIN.
//  - IDLE: cmd_ready=1.
//    - On accept with len=0 or base>=MEM_WORDS: stay IDLE, done=1 next cycle, with err=1 only for the bad base.
//    - Otherwise: addr<=base, remaining<=len, ISSUE.
//  - ISSUE: cmd_ready=0.
//    - Issue iff fifo_count + pending < FIFO_DEPTH. pending = reads issued last cycle, not yet written.
//    - On issue: mem_re=1; mem_addr = addr; addr <= (addr==MEM_WORDS-1) ? 0 : addr+1; remaining--.
//    - The issue with remaining==1 tags its word last and moves to DRAIN.
//  - DRAIN: no issues.
//    - When the last-tagged word is accepted (out_valid && out_ready && out_last): done=1 for one cycle, IDLE.
//    - A new command can be accepted the cycle after done.
//  Datapath:
//    - Each issued read carries a last tag through a 1-stage pending register.
//    - In the next cycle, {tag, mem_data} is written into the FIFO (DATA_W+1 bits).
//    - out_* is driven from the FIFO head.
//    - Push and pop in the same cycle are legal at any occupancy; count unchanged.
//  Latency and throughput:
//    - Accept in cycle 0 -> mem_addr valid cycle 1 -> mem_data cycle 2 -> out_valid cycle 3.
//    - With out_ready held high, 1 word/cycle is sustained.
//  Stream rules:
//    - out_data/out_last hold stable while out_valid && !out_ready.
//    - No word is ever lost or duplicated; the FIFO never overflows (credit check).
//  Lengths:
//    - cmd_len counts words.
//    - cmd_len > MEM_WORDS is legal and wraps repeatedly.
//  mem_addr holds its last value when idle.
// STRUCTURE
//  Shared package: ADDR_W/DATA_W/MEM_WORDS constants (shared with the memory and its writer), FSM state enum.
//  Sub-module: issue_stream_fifo: sync FIFO, width DATA_W+1, depth FIFO_DEPTH, count output.
// TESTING
//  - Memory model preloaded mem[i]=i, cmd base=16 len=4, out_ready=1:
//    - out_data 16,17,18,19 in cycles 3..6
//    - out_last only on 19
//    - done the cycle 19 is accepted
//  - Same cmd, out_ready low cycles 3-8:
//    - mem_re stops after FIFO_DEPTH credits
//    - out_data holds 16
//    - all 4 words then delivered in order, no loss
//  - base=61439 len=3: mem_addr 61439,0,1 and out_data sequence matches; err=0.
//  - len=0 -> done pulse, err=0, no mem_re, no out_valid. base=61440 len=5 -> done+err pulse, no mem_re.
//  - Reset mid-transfer: rst_n=0 at cycle 4 of a len=10 cmd.
//    - Outputs 0 immediately
//    - After release, a new cmd base=0 len=2 yields only 0,1 with last on 1
//  - Back-to-back: cmd len=1 then len=1 offered continuously.
//    - Second accepted the cycle after first done
//    - Each word has out_last=1

Source files
------------

// File: rtl/issue_mem_streamer_pkg.sv
// Constants shared by the issue memory, its writer and this read streamer,
// plus the streamer FSM encoding.
package issue_mem_streamer_pkg;

    localparam int ISM_ADDR_W     = 16;
    localparam int ISM_DATA_W     = 18;
    localparam int ISM_MEM_WORDS  = 61440;
    localparam int ISM_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } ism_state_e;

endpackage

// File: rtl/issue_stream_fifo.sv
// Small synchronous FIFO with occupancy count. Caller guarantees no push
// when full and no pop when empty; simultaneous push/pop is always legal.
module issue_stream_fifo #(
    parameter  int W     = 19,
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr] <= wdata;
                r_wr        <= ptr_inc(r_wr);
            end
            if (pop) r_rd <= ptr_inc(r_rd);
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata = r_mem[r_rd];
    assign count = r_count;

endmodule

// File: rtl/issue_mem_streamer.sv
// Walks {base,len} commands through one registered-read memory port and
// returns the words as a valid/ready stream tagged with last.
module issue_mem_streamer
    import issue_mem_streamer_pkg::*;
#(
    parameter int ADDR_W     = ISM_ADDR_W,
    parameter int DATA_W     = ISM_DATA_W,
    parameter int MEM_WORDS  = ISM_MEM_WORDS,
    parameter int FIFO_DEPTH = ISM_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [15:0]       cmd_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    ism_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_remaining;
    logic              r_pend_vld, r_pend_last;
    logic              r_nop_done, r_nop_err;
    logic              w_accept, w_bad_base, w_nop, w_credit, w_issue;
    logic              w_pop, w_last_pop;
    logic [DATA_W:0]   w_head;
    logic [CW-1:0]     w_count;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_bad_base = 32'(cmd_base) >= MEM_WORDS;
    assign w_nop      = (cmd_len == 16'd0) || w_bad_base;
    // The in-flight read counts against FIFO space so a stalled sink can never overflow it.
    assign w_credit   = (32'(w_count) + 32'(r_pend_vld)) < FIFO_DEPTH;

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && !w_nop) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_issue = w_credit;
                if (w_credit && r_remaining == 16'd1) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if (w_last_pop) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_last <= 1'b0;
            r_nop_done  <= 1'b0;
            r_nop_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_nop_done  <= w_accept && w_nop;
            r_nop_err   <= w_accept && w_bad_base;
            r_pend_vld  <= w_issue;
            r_pend_last <= w_issue && (r_remaining == 16'd1);
            if (w_accept && !w_nop) begin
                r_addr      <= cmd_base;
                r_remaining <= cmd_len;
            end else if (w_issue) begin
                r_remaining <= r_remaining - 16'd1;
                // Final issue leaves the address alone so mem_addr rests on the last word read.
                if (r_remaining != 16'd1)
                    r_addr <= (32'(r_addr) == MEM_WORDS - 1) ? '0 : r_addr + 1'b1;
            end
        end
    end

    issue_stream_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_pend_vld),
        .wdata ({r_pend_last, mem_data}),
        .pop   (w_pop),
        .rdata (w_head),
        .count (w_count)
    );

    assign out_valid  = (w_count != '0);
    assign out_data   = out_valid ? w_head[DATA_W-1:0] : '0;
    assign out_last   = out_valid && w_head[DATA_W];
    assign w_pop      = out_valid && out_ready;
    assign w_last_pop = w_pop && w_head[DATA_W];

    assign mem_addr = r_addr;
    assign mem_re   = w_issue;
    assign busy     = (r_state != S_IDLE) || r_nop_done;
    assign done     = r_nop_done || ((r_state == S_DRAIN) && w_last_pop);
    assign err      = r_nop_err;

endmodule

// File: tb/tb_issue_mem_streamer.sv
// Bench for issue_mem_streamer: directed cycle-exact scenarios plus a random
// command/backpressure run scored against an address-walk reference queue.
module tb_issue_mem_streamer;

    localparam int MW    = 61440;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_base = '0;
    logic [15:0] cmd_len = '0;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [17:0] mem_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [17:0] out_data;
    logic        out_last;
    logic        busy, done, err;

    int cmp_cnt = 0;
    int mis_cnt = 0;

    always #5 clk = ~clk;

    // Memory preloaded with mem[i] = i, one-cycle registered read.
    always @(posedge clk) mem_data <= 18'(mem_addr);

    issue_mem_streamer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        cmp_cnt++; if (cmd_ready !== 1'b1) begin mis_cnt++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        cmp_cnt++; if ({mem_re, out_valid, out_last, busy, done, err} !== 6'b0) begin
            mis_cnt++; $display("FAIL reset_flags got %b want 000000", {mem_re, out_valid, out_last, busy, done, err}); end
        cmp_cnt++; if (out_data !== 18'd0 || mem_addr !== 16'd0) begin
            mis_cnt++; $display("FAIL reset_buses got data=%0d addr=%0d want 0/0", out_data, mem_addr); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(posedge clk); #1; cmd_valid = 1'b1; cmd_base = 16; cmd_len = 4; out_ready = 1'b1; #3;
        cmp_cnt++; if (cmd_ready !== 1'b1) begin mis_cnt++; $display("FAIL basic_accept got %b want 1", cmd_ready); end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1; cmd_valid = 1'b0; #3;
            if (c == 1) begin
                cmp_cnt++; if (mem_re !== 1'b1 || mem_addr !== 16'd16 || busy !== 1'b1) begin
                    mis_cnt++; $display("FAIL basic_issue1 got re=%b addr=%0d busy=%b want 1/16/1", mem_re, mem_addr, busy); end
            end
            cmp_cnt++; if (out_valid !== 1'(c >= 3 && c <= 6)) begin
                mis_cnt++; $display("FAIL basic_valid c%0d got %b", c, out_valid); end
            if (c >= 3 && c <= 6) begin
                cmp_cnt++; if (out_data !== 18'(13 + c) || out_last !== 1'(c == 6)) begin
                    mis_cnt++; $display("FAIL basic_word c%0d got %0d/%b want %0d/%b", c, out_data, out_last, 13 + c, c == 6); end
            end
            cmp_cnt++; if (done !== 1'(c == 6)) begin mis_cnt++; $display("FAIL basic_done c%0d got %b", c, done); end
        end
    endtask

    task automatic test_stall();
        for (int t = 0; t < 2; t++) begin
            int len = (t == 0) ? 4 : 8;
            int nre = 0, got = 0;
            bit fin = 0;
            @(posedge clk); #1; cmd_valid = 1'b1; cmd_base = 16; cmd_len = 16'(len); out_ready = 1'b0; #3;
            for (int c = 1; c <= 8; c++) begin
                @(posedge clk); #1; cmd_valid = 1'b0; #3;
                if (mem_re) nre++;
                if (c >= 3) begin
                    cmp_cnt++; if (out_valid !== 1'b1 || out_data !== 18'd16) begin
                        mis_cnt++; $display("FAIL stall_hold len%0d c%0d got %b/%0d want 1/16", len, c, out_valid, out_data); end
                end
            end
            cmp_cnt++; if (nre != DEPTH) begin mis_cnt++; $display("FAIL stall_credits len%0d got %0d want %0d", len, nre, DEPTH); end
            for (int c = 0; c < 40 && !fin; c++) begin
                @(posedge clk); #1; out_ready = 1'b1; #3;
                if (out_valid) begin
                    cmp_cnt++; if (out_data !== 18'(16 + got) || out_last !== 1'(got == len - 1)) begin
                        mis_cnt++; $display("FAIL stall_word len%0d #%0d got %0d/%b want %0d", len, got, out_data, out_last, 16 + got); end
                    got++;
                end
                if (done) fin = 1;
            end
            cmp_cnt++; if (got != len || !fin) begin mis_cnt++; $display("FAIL stall_total len%0d got %0d words done=%b", len, got, fin); end
        end
    endtask

    task automatic test_wrap();
        int exp_a [3] = '{61439, 0, 1};
        @(posedge clk); #1; cmd_valid = 1'b1; cmd_base = 16'(61439); cmd_len = 3; out_ready = 1'b1; #3;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1; cmd_valid = 1'b0; #3;
            if (c <= 3) begin
                cmp_cnt++; if (mem_re !== 1'b1 || mem_addr !== 16'(exp_a[c-1])) begin
                    mis_cnt++; $display("FAIL wrap_addr c%0d got %b/%0d want 1/%0d", c, mem_re, mem_addr, exp_a[c-1]); end
            end
            if (c >= 3 && c <= 5) begin
                cmp_cnt++; if (out_valid !== 1'b1 || out_data !== 18'(exp_a[c-3]) || out_last !== 1'(c == 5)) begin
                    mis_cnt++; $display("FAIL wrap_word c%0d got %b/%0d/%b want %0d", c, out_valid, out_data, out_last, exp_a[c-3]); end
            end
            cmp_cnt++; if (done !== 1'(c == 5) || err !== 1'b0) begin
                mis_cnt++; $display("FAIL wrap_done c%0d got done=%b err=%b", c, done, err); end
        end
    endtask

    task automatic test_nop();
        for (int t = 0; t < 2; t++) begin
            bit bad = (t == 1);
            @(posedge clk); #1; cmd_valid = 1'b1;
            cmd_base = bad ? 16'(MW) : 16'd5; cmd_len = bad ? 16'd5 : 16'd0; #3;
            cmp_cnt++; if (cmd_ready !== 1'b1) begin mis_cnt++; $display("FAIL nop_accept t%0d got %b", t, cmd_ready); end
            for (int c = 1; c <= 4; c++) begin
                @(posedge clk); #1; cmd_valid = 1'b0; #3;
                cmp_cnt++; if (mem_re !== 1'b0 || out_valid !== 1'b0) begin
                    mis_cnt++; $display("FAIL nop_quiet t%0d c%0d got re=%b valid=%b", t, c, mem_re, out_valid); end
                cmp_cnt++; if (done !== 1'(c == 1) || err !== 1'(c == 1 && bad)) begin
                    mis_cnt++; $display("FAIL nop_pulse t%0d c%0d got done=%b err=%b", t, c, done, err); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        @(posedge clk); #1; cmd_valid = 1'b1; cmd_base = 100; cmd_len = 10; out_ready = 1'b1; #3;
        for (int c = 1; c <= 3; c++) begin @(posedge clk); #1; cmd_valid = 1'b0; #3; end
        @(posedge clk); #1; rst_n = 1'b0; #1;
        cmp_cnt++; if ({out_valid, mem_re, busy, done, err, out_last} !== 6'b0 || cmd_ready !== 1'b1) begin
            mis_cnt++; $display("FAIL rstmid_outputs got %b ready=%b want 000000/1", {out_valid, mem_re, busy, done, err, out_last}, cmd_ready); end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b1; cmd_base = 0; cmd_len = 2; #3;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1; cmd_valid = 1'b0; #3;
            cmp_cnt++; if (done === 1'b1 && err !== 1'b0) begin mis_cnt++; $display("FAIL rstmid_err got %b", err); end
            if (out_valid) begin
                cmp_cnt++; if (out_data !== 18'(got) || out_last !== 1'(got == 1)) begin
                    mis_cnt++; $display("FAIL rstmid_word #%0d got %0d/%b want %0d/%b", got, out_data, out_last, got, got == 1); end
                got++;
            end
        end
        cmp_cnt++; if (got != 2) begin mis_cnt++; $display("FAIL rstmid_count got %0d want 2", got); end
    endtask

    task automatic test_back_to_back();
        int acc_c [2];
        int done_c [2];
        int n_acc = 0, n_done = 0, n_w = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            cmd_valid = (n_acc < 2); cmd_base = 16'(50 + n_acc); cmd_len = 1; #3;
            if (cmd_valid && cmd_ready) begin acc_c[n_acc] = c; n_acc++; end
            if (done && n_done < 2) begin done_c[n_done] = c; n_done++; end
            if (out_valid) begin
                cmp_cnt++; if (out_last !== 1'b1 || out_data !== 18'(50 + n_w)) begin
                    mis_cnt++; $display("FAIL b2b_word #%0d got %0d/%b want %0d/1", n_w, out_data, out_last, 50 + n_w); end
                n_w++;
            end
        end
        cmd_valid = 1'b0;
        cmp_cnt++; if (n_acc != 2 || n_done != 2 || n_w != 2) begin
            mis_cnt++; $display("FAIL b2b_counts got acc=%0d done=%0d words=%0d want 2/2/2", n_acc, n_done, n_w); end
        else begin
            cmp_cnt++; if (acc_c[1] != done_c[0] + 1) begin
                mis_cnt++; $display("FAIL b2b_gap got accept2=%0d want %0d", acc_c[1], done_c[0] + 1); end
        end
    endtask

    task automatic test_random();
        int q_data[$];
        bit q_last[$];
        logic [15:0] bases [24];
        logic [15:0] lens [24];
        int n_bad = 0, n_done = 0, n_err = 0, sent = 0, cyc = 0;
        bit prev_stall = 0;
        logic [17:0] prev_d = '0;
        logic prev_l = 1'b0;
        for (int i = 0; i < 24; i++) begin
            int r = $urandom_range(0, 9);
            if (r == 0)      bases[i] = 16'($urandom_range(MW, 65535));
            else if (r <= 2) bases[i] = 16'($urandom_range(MW - 10, MW - 1));
            else             bases[i] = 16'($urandom_range(0, MW - 1));
            lens[i] = (r == 3) ? 16'd0 : 16'($urandom_range(1, 12));
            if (int'(bases[i]) >= MW) n_bad++;
            else for (int k = 0; k < int'(lens[i]); k++) begin
                q_data.push_back((int'(bases[i]) + k) % MW);
                q_last.push_back(k == int'(lens[i]) - 1);
            end
        end
        while (n_done < 24 && cyc < 4000) begin
            @(posedge clk); #1;
            cmd_valid = (sent < 24) && ($urandom_range(0, 3) != 0);
            if (sent < 24) begin cmd_base = bases[sent]; cmd_len = lens[sent]; end
            out_ready = ($urandom_range(0, 9) < 7);
            #3;
            cyc++;
            if (prev_stall) begin
                cmp_cnt++; if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
                    mis_cnt++; $display("FAIL rand_stable cyc%0d got %b/%0d/%b want 1/%0d/%b", cyc, out_valid, out_data, out_last, prev_d, prev_l); end
            end
            prev_stall = out_valid && !out_ready; prev_d = out_data; prev_l = out_last;
            if (cmd_valid && cmd_ready) sent++;
            if (done) n_done++;
            if (err) begin
                n_err++;
                cmp_cnt++; if (done !== 1'b1) begin mis_cnt++; $display("FAIL rand_err_without_done cyc%0d", cyc); end
            end
            if (out_valid && out_ready) begin
                cmp_cnt++;
                if (q_data.size() == 0) begin mis_cnt++; $display("FAIL rand_extra_word got %0d want none", out_data); end
                else begin
                    if (out_data !== 18'(q_data[0]) || out_last !== q_last[0]) begin
                        mis_cnt++; $display("FAIL rand_word got %0d/%b want %0d/%b", out_data, out_last, q_data[0], q_last[0]); end
                    void'(q_data.pop_front()); void'(q_last.pop_front());
                end
            end
        end
        cmd_valid = 1'b0; out_ready = 1'b1;
        cmp_cnt++; if (cyc >= 4000 || q_data.size() != 0) begin
            mis_cnt++; $display("FAIL rand_timeout got done=%0d left=%0d want 24/0", n_done, q_data.size()); end
        cmp_cnt++; if (n_err != n_bad) begin mis_cnt++; $display("FAIL rand_errs got %0d want %0d", n_err, n_bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_nop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
